// File: rtl/dec4_16_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dec4_16_rr_arbiter_if
// Brief    : Request/grant bundle between 16 requesters and the round-robin
//            4:16 decode arbiter. The master drives requests and enable; the
//            slave (arbiter) returns the one-hot grant and its encoded id.
// Revision : 1.0  initial release
// ============================================================================
interface dec4_16_rr_arbiter_if;
  logic        en;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        busy;
  logic        timeout;

  modport master (
    output en,
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/dec4_16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dec4_16_rr_arbiter
// Brief    : Round-robin arbiter for 16 requesters sharing one 4:16 decoder
//            select path. One winner per arbitration, searched upward from a
//            rotating pointer. The winner's code is decoded to a registered
//            one-hot grant that is held until the winner drops its request.
//            Optional macro DEC_ARB_TIMEOUT_EN adds a hold counter that forces
//            a release after MAX_HOLD grant cycles and pulses timeout.
// Revision : 1.0  initial release
// ============================================================================
module dec4_16_rr_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  dec4_16_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  ptr;
  logic [3:0]  winner;
  logic [3:0]  scan_idx;
  logic        req_any;

  logic [15:0] grant_q;
  logic [3:0]  grant_id_q;
  logic        busy_q;

  logic        holder_req;
  logic        force_rel;
  logic        release_now;

  // Out-of-range hold limits are rejected at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("dec4_16_rr_arbiter: MAX_HOLD must be within 1..255");
  end

  // Rotating-priority search: the lowest offset from ptr with a set request wins.
  always_comb begin
    winner   = ptr;
    req_any  = 1'b0;
    scan_idx = ptr;
    for (int i = 15; i >= 0; i--) begin
      scan_idx = ptr + 4'(i);
      if (bus.req[scan_idx]) begin
        winner  = scan_idx;
        req_any = 1'b1;
      end
    end
  end

  assign holder_req  = bus.req[grant_id_q];
  assign release_now = (state == S_BUSY) && (!holder_req || force_rel);

`ifdef DEC_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  // A holder that still requests once its budget is used up is forced off.
  assign force_rel = (state == S_BUSY) && holder_req && (hold_cnt == HOLD_LIMIT);

  // Hold counter starts at 1 on the granting edge and saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (state == S_IDLE) begin
      if (bus.en && req_any) begin
        hold_cnt <= 8'd1;
      end
    end else if (!release_now && hold_cnt != 8'hFF) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // Timeout pulse lines up with the grant returning to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: grant from IDLE on any enabled request, leave BUSY on release.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.en && req_any) state_next = S_BUSY;
      S_BUSY: if (release_now)       state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Grant datapath: decode the winner on entry, clear and rotate ptr on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q    <= 16'h0000;
      grant_id_q <= 4'h0;
      busy_q     <= 1'b0;
      ptr        <= 4'h0;
    end else if (state == S_IDLE) begin
      if (bus.en && req_any) begin
        grant_id_q <= winner;
        grant_q    <= 16'h0001 << winner;
        busy_q     <= 1'b1;
      end
    end else if (release_now) begin
      grant_q <= 16'h0000;
      busy_q  <= 1'b0;
      ptr     <= grant_id_q + 4'd1;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dec4_16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec4_16_rr_arbiter
// Brief    : Self-checking bench for dec4_16_rr_arbiter. A behavioural model
//            (pointer, holder id, hold length) predicts outputs each cycle;
//            directed scenarios add literal expectations, then random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_dec4_16_rr_arbiter;

  localparam int TB_MAX_HOLD = 4;
`ifdef DEC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  dec4_16_rr_arbiter_if arb_bus();

  dec4_16_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the grant, for how long, and where priority starts.
  int m_ptr, m_id, m_hold;
  bit m_busy, m_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_id = 0; m_hold = 0; m_busy = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (arb_bus.en && arb_bus.req != 16'h0) begin
          for (int k = 15; k >= 0; k--)
            if (arb_bus.req[(m_ptr + k) % 16]) m_id = (m_ptr + k) % 16;
          m_busy = 1; m_hold = 1;
        end
      end else if (!arb_bus.req[m_id]) begin
        m_busy = 0; m_ptr = (m_id + 1) % 16;
      end else if (TO_EN && m_hold == TB_MAX_HOLD) begin
        m_busy = 0; m_ptr = (m_id + 1) % 16; m_to = 1;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
  end

  // Every cycle out of reset: DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("grant",    32'(arb_bus.grant),    m_busy ? (32'h1 << m_id) : 32'h0);
      check("grant_id", 32'(arb_bus.grant_id), 32'(m_id));
      check("busy",     32'(arb_bus.busy),     32'(m_busy));
      check("timeout",  32'(arb_bus.timeout),  32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!arb_bus.busy && n < 40) begin tick(); n++; end
    if (!arb_bus.busy) check({name, "_wait_expired"}, 32'(n), 32'd40 + 32'd1);
  endtask

  int cnt;
  logic [31:0] r;

  initial begin
    arb_bus.en  = 1'b1;
    arb_bus.req = 16'h0000;
    do_reset();

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_grant", 32'(arb_bus.grant), 32'h0);
      check("idle_busy",  32'(arb_bus.busy), 32'h0);
      check("idle_id",    32'(arb_bus.grant_id), 32'h0);
    end

    // Single requester 4, one-cycle latency both ways, ptr moves to 5.
    arb_bus.req = 16'h0010; tick();
    check("single_grant", 32'(arb_bus.grant), 32'h0010);
    check("single_id",    32'(arb_bus.grant_id), 32'd4);
    arb_bus.req = 16'h0000; tick();
    check("single_release", 32'(arb_bus.grant), 32'h0);
    arb_bus.req = 16'hFFFF; tick();
    check("ptr_after_4", 32'(arb_bus.grant_id), 32'd5);
    arb_bus.req = 16'h0000; tick(); tick();

    // Full round robin from ptr=0.
    do_reset();
    arb_bus.req = 16'hFFFF;
    for (int n = 0; n <= 16; n++) begin
      wait_busy("rr");
      check("rr_id", 32'(arb_bus.grant_id), 32'(n % 16));
      tick();
      arb_bus.req[arb_bus.grant_id] = 1'b0;
      tick();
      check("rr_bubble", 32'(arb_bus.busy), 32'h0);
      arb_bus.req = 16'hFFFF;
    end
    arb_bus.req = 16'h0000; tick(); tick();

    // Wrap: ptr=14 after serving 13; req 0,2 -> 0 then 2.
    do_reset();
    arb_bus.req = 16'h2000;
    wait_busy("wrap");
    check("wrap_first", 32'(arb_bus.grant_id), 32'd13);
    arb_bus.req = 16'h0000; tick();
    arb_bus.req = 16'h0005; tick();
    check("wrap_id0", 32'(arb_bus.grant_id), 32'd0);
    arb_bus.req = 16'h0004; tick(); tick();
    check("wrap_id2", 32'(arb_bus.grant_id), 32'd2);
    arb_bus.req = 16'h0000; tick(); tick();

    // Held request on 7: forced release with timeout, or indefinite hold.
    do_reset();
    arb_bus.req = 16'h0080;
    wait_busy("hold");
    cnt = 0;
    while (arb_bus.busy && cnt < 25) begin cnt++; tick(); end
    if (TO_EN) begin
      check("hold_cycles",  32'(cnt), 32'(TB_MAX_HOLD));
      check("hold_timeout", 32'(arb_bus.timeout), 32'h1);
      tick();
      check("hold_regrant", 32'(arb_bus.grant), 32'h0080);
      check("hold_to_clr",  32'(arb_bus.timeout), 32'h0);
    end else begin
      check("hold_cycles",  32'(cnt), 32'd25);
      check("hold_timeout", 32'(arb_bus.timeout), 32'h0);
    end
    arb_bus.req = 16'h0000; tick(); tick();

    // Asynchronous reset while requester 9 holds the grant.
    do_reset();
    arb_bus.req = 16'h0300;
    wait_busy("arst");
    arb_bus.req = 16'h0200; tick(); tick();
    arb_bus.req = 16'h2200; tick();
    arb_bus.req = 16'h0200; tick();
    wait_busy("arst9");
    check("arst_pre_id", 32'(arb_bus.grant_id), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("arst_grant", 32'(arb_bus.grant), 32'h0);
    check("arst_busy",  32'(arb_bus.busy), 32'h0);
    check("arst_id",    32'(arb_bus.grant_id), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    check("arst_regrant", 32'(arb_bus.grant_id), 32'd9);
    check("arst_regrant_v", 32'(arb_bus.grant), 32'h0200);
    arb_bus.req = 16'h0000; tick(); tick();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      arb_bus.en = ($urandom_range(0, 3) != 0);
      r = $urandom & $urandom;
      if (m_busy && $urandom_range(0, 3) != 0) r[m_id] = 1'b1;
      arb_bus.req = r[15:0];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
